// File: rtl/spart_bus_arb_pkg.sv
// Shared types and constants for the SPART register-bus arbiter.
//   spart_ioaddr_t : SPART register select (DBUF/SREG/DBL/DBH)
//   arb_state_t    : bus-master FSM states
//   req_eligible   : decides whether a request can be issued given the SPART queue flags
package spart_bus_arb_pkg;

    localparam int unsigned DIV_W  = 13;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned N_REQ  = 2;
    localparam int unsigned CLK_HZ = 50_000_000;

    typedef enum logic [1:0] {
        ADDR_DBUF = 2'b00,
        ADDR_SREG = 2'b01,
        ADDR_DBL  = 2'b10,
        ADDR_DBH  = 2'b11
    } spart_ioaddr_t;

    typedef enum logic [1:0] {
        INIT_DBH,
        INIT_DBL,
        IDLE,
        ACCESS
    } arb_state_t;

    // Divisor = system clock / baud rate, truncated to the divisor register width.
    function automatic logic [DIV_W-1:0] calc_baud_div(input int unsigned baud);
        return DIV_W'(CLK_HZ / baud);
    endfunction

    localparam logic [DIV_W-1:0] BAUD_DIV_115200 = calc_baud_div(115200);

    // DBUF accesses depend on queue room/data; all other registers are always reachable.
    function automatic logic req_eligible(input logic          we,
                                          input spart_ioaddr_t addr,
                                          input logic          tx_full,
                                          input logic          rx_empty);
        if (addr != ADDR_DBUF) begin
            return 1'b1;
        end
        return we ? !tx_full : !rx_empty;
    endfunction

endpackage

// File: rtl/spart_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_elig     : per-requester eligibility mask
//   i_take     : the current grant is being used this cycle (advances the pointer)
//   o_grant_c  : one-hot grant, combinational from i_elig and the pointer
module spart_rr_arb2
    import spart_bus_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] i_elig,
    input  logic             i_take,
    output logic [N_REQ-1:0] o_grant_c
);

    logic r_rr_ptr;
    logic [N_REQ-1:0] w_grant;

    // A lone eligible requester always wins; on contention the favoured one wins.
    always_comb begin
        w_grant = '0;
        unique case (i_elig)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_rr_ptr ? 2'b10 : 2'b01;
            default: w_grant = 2'b00;
        endcase
    end

    assign o_grant_c = w_grant;

    // Favoured requester toggles after every grant that is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= 1'b0;
        end else if (i_take && (w_grant != '0)) begin
            r_rr_ptr <= ~r_rr_ptr;
        end
    end

endmodule

// File: rtl/spart_bus_arb.sv
// Arbitrated master for the SPART register bus. Programs the baud divisor after
// reset, then shares the bus between requester 0 (processor) and 1 (loader/debug).
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/we/addr/wdata : per-requester access request, held until accepted
//   req_ready             : one-hot acceptance (combinational, IDLE only)
//   rsp_valid             : one-cycle completion pulse to the owner
//   rsp_rdata             : last read data, shared by both requesters
//   init_done             : baud divisor has been programmed
//   tx_q_full, rx_q_empty : SPART queue status
//   iocs_n/iorw_n/ioaddr/databus : SPART register bus (registered controls)
module spart_bus_arb
    import spart_bus_arb_pkg::*;
#(
    parameter logic [DIV_W-1:0] BAUD_DIV = BAUD_DIV_115200,
    parameter bit               INIT_EN  = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ-1:0]    req_we,
    input  spart_ioaddr_t       req_addr  [N_REQ],
    input  logic [DATA_W-1:0]   req_wdata [N_REQ],
    output logic [N_REQ-1:0]    req_ready,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                init_done,
    input  logic                tx_q_full,
    input  logic                rx_q_empty,
    output logic                iocs_n,
    output logic                iorw_n,
    output spart_ioaddr_t       ioaddr,
    inout  wire  [DATA_W-1:0]   databus
);

    arb_state_t          r_state;
    logic                r_owner;
    logic [DATA_W-1:0]   r_dout;

    logic [N_REQ-1:0]    w_elig;
    logic [N_REQ-1:0]    w_grant;
    logic                w_idle;
    logic                w_accept;
    logic                w_sel;

    // Per-requester eligibility from the SPART queue flags.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            w_elig[i] = req_valid[i] &&
                        req_eligible(req_we[i], req_addr[i], tx_q_full, rx_q_empty);
        end
    end

    spart_rr_arb2 u_rr_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_elig    (w_elig),
        .i_take    (w_accept),
        .o_grant_c (w_grant)
    );

    assign w_idle    = (r_state == IDLE);
    assign w_accept  = w_idle && (w_grant != '0);
    assign w_sel     = w_grant[1];
    assign req_ready = w_idle ? w_grant : '0;

    // Write data is only driven while a write is on the bus.
    assign databus = (!iocs_n && !iorw_n) ? r_dout : {DATA_W{1'bz}};

    // Bus-master FSM: each transition registers the bus cycle that follows it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (INIT_EN) begin
                r_state <= INIT_DBH;
            end else begin
                r_state <= IDLE;
            end
            r_owner   <= 1'b0;
            r_dout    <= '0;
            iocs_n    <= 1'b1;
            iorw_n    <= 1'b1;
            ioaddr    <= ADDR_DBUF;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            init_done <= 1'b0;
        end else begin
            rsp_valid <= '0;
            iocs_n    <= 1'b1;
            iorw_n    <= 1'b1;
            unique case (r_state)
                INIT_DBH: begin
                    iocs_n  <= 1'b0;
                    iorw_n  <= 1'b0;
                    ioaddr  <= ADDR_DBH;
                    r_dout  <= DATA_W'(BAUD_DIV >> 8);
                    r_state <= INIT_DBL;
                end
                INIT_DBL: begin
                    iocs_n    <= 1'b0;
                    iorw_n    <= 1'b0;
                    ioaddr    <= ADDR_DBL;
                    r_dout    <= BAUD_DIV[DATA_W-1:0];
                    init_done <= 1'b1;
                    r_state   <= IDLE;
                end
                IDLE: begin
                    // With the init writes skipped the divisor is left as-is; report ready.
                    init_done <= 1'b1;
                    if (w_accept) begin
                        iocs_n  <= 1'b0;
                        iorw_n  <= ~req_we[w_sel];
                        ioaddr  <= req_addr[w_sel];
                        r_dout  <= req_wdata[w_sel];
                        r_owner <= w_sel;
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    // iorw_n still holds the latched direction of this access.
                    if (iorw_n) begin
                        rsp_rdata <= databus;
                    end
                    rsp_valid[r_owner] <= 1'b1;
                    r_state            <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spart_bus_arb.sv
// Bench for spart_bus_arb: behavioural SPART register model on the bus plus a
// transaction-level reference of grants, bus cycles and responses.
module tb_spart_bus_arb;
    import spart_bus_arb_pkg::*;

    function automatic int calculate_baud(input int baud);
        return 50_000_000 / baud;
    endfunction

    localparam logic [DIV_W-1:0] TB_DIV = DIV_W'(calculate_baud(19200));

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] req_valid, req_we, req_ready, rsp_valid;
    spart_ioaddr_t req_addr [2];
    logic [7:0] req_wdata [2];
    logic [7:0] rsp_rdata;
    logic init_done, tx_q_full, rx_q_empty, iocs_n, iorw_n;
    spart_ioaddr_t ioaddr;
    wire [7:0] databus;

    always #5 clk = ~clk;

    spart_bus_arb #(.BAUD_DIV(TB_DIV), .INIT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .init_done(init_done), .tx_q_full(tx_q_full), .rx_q_empty(rx_q_empty),
        .iocs_n(iocs_n), .iorw_n(iorw_n), .ioaddr(ioaddr), .databus(databus)
    );

    // ---------------- SPART register model ----------------
    logic [7:0] dev_sreg, dev_dbl, dev_dbh, dev_head, dev_rd;
    logic [7:0] rxq [$];
    int tx_count;

    task automatic refresh_rx();
        rx_q_empty = (rxq.size() == 0);
        dev_head   = (rxq.size() == 0) ? 8'h00 : rxq[0];
    endtask

    always_comb begin
        dev_rd = 8'h00;
        case (ioaddr)
            ADDR_DBUF: dev_rd = dev_head;
            ADDR_SREG: dev_rd = dev_sreg;
            ADDR_DBL:  dev_rd = dev_dbl;
            default:   dev_rd = dev_dbh;
        endcase
    end

    assign databus = (!iocs_n && iorw_n) ? dev_rd : 8'hzz;

    initial begin : spart_model
        logic do_pop, do_wr;
        spart_ioaddr_t a;
        logic [7:0] d;
        dev_dbl = 8'h00; dev_dbh = 8'h00; tx_count = 0;
        forever begin
            @(posedge clk);
            do_pop = rst_n && !iocs_n && iorw_n && (ioaddr == ADDR_DBUF);
            do_wr  = rst_n && !iocs_n && !iorw_n;
            a = ioaddr;
            d = databus;
            #1;
            if (do_pop && rxq.size() > 0) void'(rxq.pop_front());
            if (do_wr) begin
                case (a)
                    ADDR_DBL:  dev_dbl = d;
                    ADDR_DBH:  dev_dbh = d;
                    ADDR_DBUF: tx_count++;
                    default:   ;
                endcase
            end
            refresh_rx();
        end
    end

    // ---------------- reference model / scoreboard ----------------
    int n_vec = 0, n_err = 0;
    int cyc, free_at, mode;
    int unsigned p_req, p_full, p_rx;
    bit m_rr, push_55;
    bit taken [2];
    logic [7:0] m_dbl, m_dbh, m_last_rd;
    logic [10:0] exp_bus [int];   // {write, addr, data} expected on the bus in that cycle
    logic [1:0]  exp_rsp [int];
    logic [7:0]  exp_rd  [int];

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_bus.delete(); exp_rsp.delete(); exp_rd.delete();
        cyc = 0; m_rr = 1'b0; m_last_rd = 8'h00; free_at = 2;
        m_dbh = 8'(TB_DIV >> 8);
        m_dbl = TB_DIV[7:0];
        exp_bus[1] = {1'b1, ADDR_DBH, m_dbh};
        exp_bus[2] = {1'b1, ADDR_DBL, m_dbl};
        taken[0] = 1'b0; taken[1] = 1'b0;
    endtask

    task automatic check_outputs();
        logic [10:0] e;
        logic [1:0] er;
        if (exp_bus.exists(cyc)) begin
            e = exp_bus[cyc];
            chk("iocs_n_access", 16'(iocs_n), 16'(1'b0));
            chk("iorw_n", 16'(iorw_n), 16'(!e[10]));
            chk("ioaddr", 16'(ioaddr), 16'(e[9:8]));
            if (e[10]) chk("wdata", 16'(databus), 16'(e[7:0]));
        end else begin
            chk("iocs_n_idle", 16'(iocs_n), 16'(1'b1));
        end
        er = exp_rsp.exists(cyc) ? exp_rsp[cyc] : 2'b00;
        chk("rsp_valid", 16'(rsp_valid), 16'(er));
        if (exp_rd.exists(cyc)) m_last_rd = exp_rd[cyc];
        chk("rsp_rdata", 16'(rsp_rdata), 16'(m_last_rd));
        chk("init_done", 16'(init_done), 16'(cyc >= 2));
    endtask

    task automatic new_req(input int i);
        logic w;
        spart_ioaddr_t a;
        w = 1'($urandom_range(0, 1));
        a = spart_ioaddr_t'(2'($urandom_range(0, 3)));
        case (mode)
            1: begin w = 1'b0; a = ADDR_SREG; end
            2: begin
                if (i == 0) begin w = 1'b1; a = ADDR_DBUF; end
                else begin w = 1'b0; a = ADDR_SREG; end
            end
            3: begin
                if (i == 0) return;
                w = 1'b0; a = ADDR_DBUF;
            end
            default: ;
        endcase
        req_valid[i] = 1'b1;
        req_we[i]    = w;
        req_addr[i]  = a;
        req_wdata[i] = 8'($urandom);
    endtask

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            if (taken[i]) begin req_valid[i] = 1'b0; taken[i] = 1'b0; end
            if (!req_valid[i] && $urandom_range(0, 99) < p_req) new_req(i);
        end
        tx_q_full = ($urandom_range(0, 99) < p_full);
        if (push_55) begin
            rxq.push_back(8'h55); push_55 = 1'b0; refresh_rx();
        end else if ($urandom_range(0, 99) < p_rx) begin
            rxq.push_back(8'($urandom)); refresh_rx();
        end
    endtask

    // Expected acceptance from the arbitration rules, then schedule the resulting bus cycle and response.
    task automatic decide(output bit g);
        logic [1:0] elig, exp_rdy;
        logic [7:0] rd;
        bit win;
        g = 1'b0; win = 1'b0; exp_rdy = 2'b00; rd = 8'h00;
        for (int i = 0; i < 2; i++) begin
            if (req_addr[i] == ADDR_DBUF)
                elig[i] = req_valid[i] && (req_we[i] ? !tx_q_full : (rxq.size() > 0));
            else
                elig[i] = req_valid[i];
        end
        if (cyc >= free_at && elig != 2'b00) begin
            win = elig[m_rr] ? m_rr : !m_rr;
            exp_rdy[win] = 1'b1;
        end
        chk("req_ready", 16'(req_ready), 16'(exp_rdy));
        if (exp_rdy != 2'b00) begin
            g = 1'b1;
            exp_bus[cyc + 1] = {req_we[win], req_addr[win], req_wdata[win]};
            exp_rsp[cyc + 2] = exp_rdy;
            if (!req_we[win]) begin
                case (req_addr[win])
                    ADDR_DBUF: rd = rxq[0];
                    ADDR_SREG: rd = dev_sreg;
                    ADDR_DBL:  rd = m_dbl;
                    default:   rd = m_dbh;
                endcase
                exp_rd[cyc + 2] = rd;
            end else if (req_addr[win] == ADDR_DBL) begin
                m_dbl = req_wdata[win];
            end else if (req_addr[win] == ADDR_DBH) begin
                m_dbh = req_wdata[win];
            end
            m_rr = !m_rr;
            free_at = cyc + 2;
            taken[win] = 1'b1;
        end
    endtask

    // Called 1 ns after an edge; returns 1 ns after the next edge with outputs checked.
    task automatic step(output bit g);
        #1 drive();
        #1 decide(g);
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic run(input int n);
        bit g;
        for (int k = 0; k < n; k++) step(g);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 2'b11; req_we = 2'b00;
        req_addr[0] = ADDR_SREG; req_addr[1] = ADDR_SREG;
        req_wdata[0] = 8'h00; req_wdata[1] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_iocs_n", 16'(iocs_n), 16'(1'b1));
        chk("rst_iorw_n", 16'(iorw_n), 16'(1'b1));
        chk("rst_ioaddr", 16'(ioaddr), 16'(ADDR_DBUF));
        chk("rst_req_ready", 16'(req_ready), 16'(2'b00));
        chk("rst_rsp_valid", 16'(rsp_valid), 16'(2'b00));
        chk("rst_rsp_rdata", 16'(rsp_rdata), 16'(8'h00));
        chk("rst_init_done", 16'(init_done), 16'(1'b0));
        req_valid = 2'b00;
        model_reset();
        rst_n = 1'b1;
        check_outputs();
    endtask

    initial begin
        bit g;
        tx_q_full = 1'b0;
        dev_sreg = 8'($urandom);
        refresh_rx();
        mode = 0; p_req = 60; p_full = 30; p_rx = 15; push_55 = 1'b0;
        do_reset();

        // Requests present during init, then mixed random traffic.
        run(60);

        // Both requesters continuously reading SREG.
        mode = 1; p_req = 100;
        run(24);

        // DBUF writes stall while TX is full; SREG reads keep flowing.
        mode = 2; p_full = 100; p_rx = 0;
        run(20);
        p_full = 0;
        run(10);

        // DBUF read waits for RX data, then returns 8'h55.
        mode = 3; p_full = 0; p_rx = 0;
        run(40);
        push_55 = 1'b1;
        run(8);

        // Long random run.
        mode = 0; p_req = 50; p_full = 30; p_rx = 20;
        dev_sreg = 8'($urandom);
        run(1500);

        // Reset in the middle of an ACCESS cycle.
        mode = 1; p_req = 100;
        g = 1'b0;
        for (int k = 0; k < 20 && !g; k++) step(g);
        if (!g) chk("grant_timeout", 16'(1'b0), 16'(1'b1));
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_iocs_n", 16'(iocs_n), 16'(1'b1));
        chk("midrst_rsp_valid", 16'(rsp_valid), 16'(2'b00));
        chk("midrst_init_done", 16'(init_done), 16'(1'b0));
        @(posedge clk);
        #1;
        chk("midrst_rsp_valid2", 16'(rsp_valid), 16'(2'b00));
        chk("midrst_iocs_n2", 16'(iocs_n), 16'(1'b1));
        do_reset();
        mode = 0; p_req = 60; p_full = 30; p_rx = 15;
        run(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
